// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the pushbutton debouncer.
// Holds the channel state encoding, counter widths and tick-counter sizing.
package button_pkg;

   localparam int STABLE_W = 8;
   localparam int HOLD_W   = 16;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Width of a counter that runs 0..tick_cyc-1.
   function automatic int tick_cnt_w(input int tick_cyc);
      if (tick_cyc <= 2) begin
         return 1;
      end
      return $clog2(tick_cyc);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One debounced pushbutton: synchronizer, debounce FSM, hold counter.
// Ports: clk, rst_n, tick_ms (shared 1 ms strobe), raw (async pad bit);
//        level (1 = pressed), press_evt, release_evt, long_evt (1-cycle).
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_ms,
   input  logic raw,
   output logic level,
   output logic press_evt,
   output logic release_evt,
   output logic long_evt
);

   localparam logic RAW_IDLE = ACTIVE_LOW;
   localparam logic [STABLE_W-1:0] DEB = STABLE_W'(DEBOUNCE_MS);
   localparam logic [HOLD_W-1:0] LONG = HOLD_W'(LONG_MS);

   logic sync1;
   logic sync2;
   logic pressed;

   state_t state;
   state_t state_n;

   logic [STABLE_W-1:0] stable;
   logic [STABLE_W-1:0] stable_n;
   logic [HOLD_W-1:0]   hold;
   logic [HOLD_W-1:0]   hold_n;
   logic [HOLD_W-1:0]   hold_inc;

   logic fired;
   logic fired_n;
   logic level_n;
   logic press_n;
   logic release_n;
   logic long_n;

   // Sync flops reset to the released pad level so that a button held
   // through reset is seen as a fresh press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= RAW_IDLE;
         sync2 <= RAW_IDLE;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   assign pressed  = sync2 ^ RAW_IDLE;
   assign hold_inc = (hold == LONG) ? hold : hold + 1'b1;

   // The tick that lands first after entering a wait state only closes a
   // partial interval, so acceptance waits for one tick beyond DEBOUNCE_MS
   // counted ticks: that guarantees DEBOUNCE_MS whole ms of stability.
   always_comb begin
      state_n   = state;
      stable_n  = stable;
      hold_n    = hold;
      fired_n   = fired;
      level_n   = level;
      press_n   = 1'b0;
      release_n = 1'b0;
      long_n    = 1'b0;
      case (state)
         IDLE: begin
            if (pressed) begin
               state_n  = PRESS_WAIT;
               stable_n = '0;
            end
         end
         PRESS_WAIT: begin
            if (!pressed) begin
               state_n = IDLE;
            end else if (tick_ms) begin
               if (stable == DEB) begin
                  state_n = HELD;
                  press_n = 1'b1;
                  level_n = 1'b1;
                  hold_n  = '0;
               end else begin
                  stable_n = stable + 1'b1;
               end
            end
         end
         HELD: begin
            if (!pressed) begin
               state_n  = RELEASE_WAIT;
               stable_n = '0;
            end else if (tick_ms) begin
               hold_n = hold_inc;
               if (hold_inc == LONG && !fired) begin
                  long_n  = 1'b1;
                  fired_n = 1'b1;
               end
            end
         end
         RELEASE_WAIT: begin
            // Returning to HELD keeps hold count and long flag, so a
            // short release glitch neither restarts nor repeats the long.
            if (pressed) begin
               state_n = HELD;
            end else if (tick_ms) begin
               if (stable == DEB) begin
                  state_n   = IDLE;
                  release_n = 1'b1;
                  level_n   = 1'b0;
                  fired_n   = 1'b0;
                  hold_n    = '0;
               end else begin
                  stable_n = stable + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         stable      <= '0;
         hold        <= '0;
         fired       <= 1'b0;
         level       <= 1'b0;
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
         long_evt    <= 1'b0;
      end else begin
         state       <= state_n;
         stable      <= stable_n;
         hold        <= hold_n;
         fired       <= fired_n;
         level       <= level_n;
         press_evt   <= press_n;
         release_evt <= release_n;
         long_evt    <= long_n;
      end
   end

endmodule

// File: rtl/button_reader.sv
// Debounced reader for N_BTN pushbuttons sharing one 1 ms prescaler.
// Ports: clk, rst_n, btn_raw (async pads); btn_level, btn_press,
//        btn_release, btn_long per button; tick_ms shared strobe.
module button_reader
   import button_pkg::*;
#(
   parameter int CLK_HZ      = 125000000,
   parameter int N_BTN       = 4,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long,
   output logic             tick_ms
);

   localparam int TICK_RAW = CLK_HZ / 1000;
   localparam int TICK_CYC = (TICK_RAW < 2) ? 2 : TICK_RAW;
   localparam int TICK_W   = tick_cnt_w(TICK_CYC);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

   logic [TICK_W-1:0] tick_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign tick_ms = (tick_cnt == TICK_LAST);

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      button_channel #(
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .LONG_MS     (LONG_MS),
         .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick_ms     (tick_ms),
         .raw         (btn_raw[i]),
         .level       (btn_level[i]),
         .press_evt   (btn_press[i]),
         .release_evt (btn_release[i]),
         .long_evt    (btn_long[i])
      );
   end

endmodule

// File: doc/button_reader.md
# button_reader

Input-side companion to the board LED driver: samples N_BTN raw pushbuttons asynchronous to `clk` and debounces them. Emits a clean pressed level plus single-cycle press, release and long-press event pulses for control logic, including the LED pattern logic. All timing derives from one shared 1 ms tick prescaled from `clk`.

## Interface
- `CLK_HZ`, 125000000: `clk` frequency; `TICK_CYC = CLK_HZ/1000` cycles per ms tick, minimum 2.
- `N_BTN`, 4: number of buttons, 1..16.
- `DEBOUNCE_MS`, 20: stable ms ticks required to accept a change, 1..255.
- `LONG_MS`, 1000: ms ticks held, counted from press acceptance, before the long event fires; must exceed DEBOUNCE_MS, max 65535.
- `ACTIVE_LOW`, 1: 1 means a raw 0 is pressed.
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous assert, active-low reset; deassertion synchronous to `clk` externally.
- `btn_raw` in N_BTN: raw pad inputs, asynchronous.
- `btn_level` out N_BTN: debounced state, 1 = pressed.
- `btn_press` out N_BTN: 1-cycle pulse on accepted press.
- `btn_release` out N_BTN: 1-cycle pulse on accepted release.
- `btn_long` out N_BTN: 1-cycle pulse when held LONG_MS.
- `tick_ms` out 1: 1-cycle pulse every TICK_CYC cycles, for debug and other consumers.

## Operation
- Input path: 2-flop synchronizer per bit, then polarity normalisation to 1 = pressed. Sync flops reset to the released level.
- Prescaler: counter 0..TICK_CYC-1. `tick_ms` = 1 in the cycle the counter equals TICK_CYC-1, then the counter wraps to 0.
- Per-button FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: synced = 1 → PRESS_WAIT, stable count cleared.
  - PRESS_WAIT: synced = 0 → IDLE. On tick with synced = 1, stable count +1. When the count reaches DEBOUNCE_MS → HELD, `btn_press` pulse, `btn_level` = 1, hold count cleared.
  - HELD: on tick, hold count +1, saturating. When it reaches LONG_MS, `btn_long` pulse, exactly once per press. Synced = 0 → RELEASE_WAIT, stable count cleared.
  - RELEASE_WAIT: synced = 1 → HELD; hold count kept, long-event state kept. On tick with synced = 0, stable count +1. When it reaches DEBOUNCE_MS → IDLE, `btn_release` pulse, `btn_level` = 0.
- Widths: stable count 8 bits. Hold count 16 bits, saturating at LONG_MS, no wrap. Long-fired flag 1 bit per button, cleared on entry to IDLE.
- Channels are independent. Simultaneous events on different buttons assert their pulses in the same cycle.
- A change and a tick in the same cycle: the change wins. The count is cleared, not incremented.
- A button held through reset release is debounced like any new press and yields `btn_press`.

## Timing
- Reset values: all outputs 0, FSMs IDLE, counters 0.
- Reset mid-operation: immediate return to reset values. No release pulse is generated.
- Press latency: from a raw transition to `btn_press` takes 2 sync cycles + DEBOUNCE_MS ticks + 1 cycle. Range is DEBOUNCE_MS to DEBOUNCE_MS+1 ms; the jitter comes from tick phase.
- `btn_level` changes in the same cycle as the press or release pulse and stays stable between them.
- `btn_long` fires on the LONG_MS-th tick after press acceptance, registered, 1 cycle wide.
- Bounce shorter than one tick interval never produces an event.

## Structure
- Package `button_pkg`:
  - state enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - counter width constants (8, 16);
  - function for tick-counter width, `$clog2(TICK_CYC)`.
- Sub-module `button_channel`, instantiated N_BTN times:
  - contents: synchronizer, FSM, counters and pulse registers for one button;
  - inputs: `clk`, `rst_n`, `tick_ms`, raw bit;
  - parameters: DEBOUNCE_MS, LONG_MS, ACTIVE_LOW.
- Top holds the prescaler and the generate loop.

## Test plan
Bench parameters: CLK_HZ=10000 (TICK_CYC=10), DEBOUNCE_MS=3, LONG_MS=8, N_BTN=4, ACTIVE_LOW=1.
1. Reset, all `btn_raw`=1 for 200 cycles → all outputs stay 0; `tick_ms` pulses every 10 cycles.
2. `btn_raw[0]`=0 held → one `btn_press[0]` pulse 32–42 cycles later; `btn_level[0]`=1. No other bits move.
3. Continue holding → `btn_long[0]` exactly once, 8 ticks after `btn_press[0]`. Release → one `btn_release[0]` after 3–4 ticks; `btn_level[0]`=0.
4. `btn_raw[1]` toggles every 7 cycles for 300 cycles, then settles at 1 → no events on any output.
5. Press b2 and b3 in the same cycle → `btn_press[2]` and `btn_press[3]` in the same cycle. Then a 15-cycle release glitch on b2 during HELD → no release, no second press.
6. Assert `rst_n` low while b0 is HELD → outputs 0 immediately. Deassert with b0 still held → fresh `btn_press[0]` after debounce.
